// File: rtl/ex_mdu_pkg.sv
// ex_mdu_pkg: funct3 encodings, FSM states and op-decode helpers
// shared by the EX-stage multiply/divide unit and its divider core.
package ex_mdu_pkg;

  localparam int MDU_STATE_W = 3;

  typedef enum logic [MDU_STATE_W-1:0] {
    MDU_ST_IDLE = 3'd0,
    MDU_ST_PREP = 3'd1,
    MDU_ST_ITER = 3'd2,
    MDU_ST_FIN  = 3'd3,
    MDU_ST_DONE = 3'd4
  } mdu_state_e;

  localparam logic [2:0] MDU_OP_MUL    = 3'd0;
  localparam logic [2:0] MDU_OP_MULH   = 3'd1;
  localparam logic [2:0] MDU_OP_MULHSU = 3'd2;
  localparam logic [2:0] MDU_OP_MULHU  = 3'd3;
  localparam logic [2:0] MDU_OP_DIV    = 3'd4;
  localparam logic [2:0] MDU_OP_DIVU   = 3'd5;
  localparam logic [2:0] MDU_OP_REM    = 3'd6;
  localparam logic [2:0] MDU_OP_REMU   = 3'd7;

  function automatic logic op_is_mul(input logic [2:0] op);
    return ~op[2];
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic op_is_hi(input logic [2:0] op);
    return op != MDU_OP_MUL;
  endfunction

  function automatic logic op_sdiv(input logic [2:0] op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_REM);
  endfunction

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MDU_OP_MULH) || (op == MDU_OP_MULHSU) ||
           op_sdiv(op);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MDU_OP_MULH) || op_sdiv(op);
  endfunction

endpackage

// File: rtl/ex_mdu_div_core.sv
// ex_mdu_div_core: one iteration of an unsigned restoring divider,
// retiring RADIX_LOG2 quotient bits; purely combinational.
module ex_mdu_div_core #(
  parameter int XLEN       = 32,
  parameter int RADIX_LOG2 = 1
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_dvs,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_quo;
  logic [XLEN:0]   w_trial;
  logic [XLEN:0]   w_diff;

  // quo shifts dividend bits out of its MSB and quotient bits in at its LSB
  always_comb begin
    w_rem   = i_rem;
    w_quo   = i_quo;
    w_trial = '0;
    w_diff  = '0;
    for (int k = 0; k < RADIX_LOG2; k++) begin
      w_trial = {w_rem, w_quo[XLEN-1]};
      w_diff  = w_trial - {1'b0, i_dvs};
      w_quo   = {w_quo[XLEN-2:0], ~w_diff[XLEN]};
      w_rem   = w_diff[XLEN] ? w_trial[XLEN-1:0]
                             : w_diff[XLEN-1:0];
    end
    o_rem = w_rem;
    o_quo = w_quo;
  end

endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: iterative RV32M multiply/divide unit beside the EX-stage ALU.
// Define MDU_FAST_MUL_EN for a single-cycle combinational MUL* path.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int RADIX_LOG2 = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      wb_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      wb_addr_o
);

  localparam int N     = XLEN / RADIX_LOG2;
  localparam int CNT_W = $clog2(N);
  localparam int PW    = XLEN + RADIX_LOG2;
  localparam int W2    = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
`ifdef MDU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  mdu_state_e       r_state;
  mdu_state_e       w_next;
  logic [2:0]       r_op;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [4:0]       r_wb;
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic [XLEN-1:0]  r_opd;
  logic             r_neg;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_result;

  logic             w_accept;
  logic             w_mul;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_neg;
  logic [XLEN-1:0]  w_mag_a;
  logic [XLEN-1:0]  w_mag_b;
  logic             w_div0;
  logic             w_ovf;
  logic             w_special;
  logic [XLEN-1:0]  w_spec_res;
  logic [W2-1:0]    w_fast_prod;
  logic [PW-1:0]    w_pp;
  logic [W2-1:0]    w_mul_nxt;
  logic [XLEN-1:0]  w_div_rem;
  logic [XLEN-1:0]  w_div_quo;
  logic [W2-1:0]    w_prod;
  logic [W2-1:0]    w_prod_s;
  logic [XLEN-1:0]  w_dres_u;
  logic [XLEN-1:0]  w_fin_res;

  assign w_accept = (r_state == MDU_ST_IDLE) & start_i & ~flush_i;
  assign w_mul    = op_is_mul(r_op);

  // operand conditioning, evaluated while in PREP
  assign w_a_neg  = op_a_signed(r_op) & r_a[XLEN-1];
  assign w_b_neg  = op_b_signed(r_op) & r_b[XLEN-1];
  assign w_mag_a  = w_a_neg ? -r_a : r_a;
  assign w_mag_b  = w_b_neg ? -r_b : r_b;
  assign w_neg    = (!w_mul && op_is_rem(r_op)) ? w_a_neg
                                                : (w_a_neg ^ w_b_neg);

  assign w_div0    = !w_mul && (r_b == '0);
  assign w_ovf     = op_sdiv(r_op) && (r_a == MIN_NEG) && (r_b == '1);
  assign w_special = w_div0 | w_ovf;

  always_comb begin
    w_spec_res = '0;
    if (w_div0)
      w_spec_res = op_is_rem(r_op) ? r_a : '1;
    else if (w_ovf)
      w_spec_res = op_is_rem(r_op) ? '0 : r_a;
  end

`ifdef MDU_FAST_MUL_EN
  assign w_fast_prod = W2'(w_mag_a) * W2'(w_mag_b);
`else
  assign w_fast_prod = '0;
`endif

  // shift-add step: hi accumulates, lo shifts out multiplier bits
  assign w_pp      = {{RADIX_LOG2{1'b0}}, r_hi} +
                     PW'(r_opd) * PW'(r_lo[RADIX_LOG2-1:0]);
  assign w_mul_nxt = {w_pp, r_lo[XLEN-1:RADIX_LOG2]};

  ex_mdu_div_core #(
    .XLEN       (XLEN),
    .RADIX_LOG2 (RADIX_LOG2)
  ) u_div_core (
    .i_rem (r_hi),
    .i_quo (r_lo),
    .i_dvs (r_opd),
    .o_rem (w_div_rem),
    .o_quo (w_div_quo)
  );

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg ? -w_prod : w_prod;
  assign w_dres_u = op_is_rem(r_op) ? r_hi : r_lo;

  always_comb begin
    if (w_mul)
      w_fin_res = op_is_hi(r_op) ? w_prod_s[W2-1:XLEN]
                                 : w_prod_s[XLEN-1:0];
    else
      w_fin_res = r_neg ? -w_dres_u : w_dres_u;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= MDU_ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      MDU_ST_IDLE: if (w_accept) w_next = MDU_ST_PREP;
      MDU_ST_PREP: begin
        if (w_special)
          w_next = MDU_ST_DONE;
        else if (FAST_MUL && w_mul)
          w_next = MDU_ST_FIN;
        else
          w_next = MDU_ST_ITER;
      end
      MDU_ST_ITER: if (r_cnt == '0) w_next = MDU_ST_FIN;
      MDU_ST_FIN:  w_next = MDU_ST_DONE;
      MDU_ST_DONE: w_next = MDU_ST_IDLE;
      default:     w_next = MDU_ST_IDLE;
    endcase
    if (flush_i)
      w_next = MDU_ST_IDLE;
  end

  always_comb begin
    busy_o = (r_state != MDU_ST_IDLE);
    done_o = (r_state == MDU_ST_DONE) & ~flush_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_wb     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opd    <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (!flush_i) begin
      unique case (r_state)
        MDU_ST_IDLE: begin
          if (w_accept) begin
            r_op <= op_i;
            r_a  <= rs1_i;
            r_b  <= rs2_i;
            r_wb <= wb_addr_i;
          end
        end
        MDU_ST_PREP: begin
          r_cnt <= CNT_W'(N - 1);
          r_neg <= w_neg;
          if (FAST_MUL && w_mul) begin
            {r_hi, r_lo} <= w_fast_prod;
          end else if (w_mul) begin
            r_hi  <= '0;
            r_lo  <= w_mag_b;
            r_opd <= w_mag_a;
          end else begin
            r_hi  <= '0;
            r_lo  <= w_mag_a;
            r_opd <= w_mag_b;
          end
          if (w_special)
            r_result <= w_spec_res;
        end
        MDU_ST_ITER: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_mul) begin
            {r_hi, r_lo} <= w_mul_nxt;
          end else begin
            r_hi <= w_div_rem;
            r_lo <= w_div_quo;
          end
        end
        MDU_ST_FIN: r_result <= w_fin_res;
        default: ;
      endcase
    end
  end

  assign result_o  = r_result;
  assign wb_addr_o = r_wb;

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed vectors for ex_mdu with hand-computed results.
// Build with MDU_FAST_MUL_EN defined to expect the fast MUL latency.
module tb_ex_mdu;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = 35;
`endif
  localparam int DIV_LAT = 35;
  localparam int SPC_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  wb_addr_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  wb_addr_o;

  int n_chk  = 0;
  int n_fail = 0;

  ex_mdu #(
    .XLEN       (32),
    .RADIX_LOG2 (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .op_i      (op_i),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .wb_addr_i (wb_addr_i),
    .flush_i   (flush_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .wb_addr_o (wb_addr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag,
                     input logic [2:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [4:0] wb,
                     input logic [31:0] exp,
                     input int exp_lat,
                     input bit repulse);
    int lat;
    start_i   = 1'b1;
    op_i      = op;
    rs1_i     = a;
    rs2_i     = b;
    wb_addr_i = wb;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 1;
    while (!done_o && lat < 100) begin
      if (repulse && lat == 5) begin
        start_i   = 1'b1;
        op_i      = 3'd0;
        rs1_i     = 32'd3;
        rs2_i     = 32'd3;
        wb_addr_i = 5'd31;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start_i = 1'b0;
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, 64'(result_o), 64'(exp));
    chk({tag, "_wb"}, 64'(wb_addr_o), 64'(wb));
    chk({tag, "_busy"}, 64'(busy_o), 64'd1);
    @(posedge clk); #1;
    chk({tag, "_done1"}, 64'(done_o), 64'd0);
    chk({tag, "_idle"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    start_i   = 1'b0;
    flush_i   = 1'b0;
    op_i      = '0;
    rs1_i     = '0;
    rs2_i     = '0;
    wb_addr_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_res", 64'(result_o), 64'd0);
    chk("rst_wb", 64'(wb_addr_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5,
        32'hFFFF_FFEB, MUL_LAT, 1'b0);
    run("mul_lo", 3'd0, 32'h1234_5678, 32'h10, 5'd6,
        32'h2345_6780, MUL_LAT, 1'b0);
    run("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd7,
        32'h4000_0000, MUL_LAT, 1'b0);
    run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,
        32'hFFFF_FFFF, MUL_LAT, 1'b0);
    run("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,
        32'hFFFF_FFFE, MUL_LAT, 1'b0);
    run("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10,
        32'hFFFF_FFFD, DIV_LAT, 1'b0);
    run("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11,
        32'hFFFF_FFFF, DIV_LAT, 1'b0);
    run("div_nd", 3'd4, 32'd7, 32'hFFFF_FFFE, 5'd12,
        32'hFFFF_FFFD, DIV_LAT, 1'b0);
    run("rem_nd", 3'd6, 32'd7, 32'hFFFF_FFFE, 5'd13,
        32'd1, DIV_LAT, 1'b0);
    run("divu", 3'd5, 32'd100, 32'd7, 5'd14,
        32'd14, DIV_LAT, 1'b0);
    run("remu", 3'd7, 32'd100, 32'd7, 5'd15,
        32'd2, DIV_LAT, 1'b0);
    run("divu_max", 3'd5, 32'hFFFF_FFFF, 32'd1, 5'd16,
        32'hFFFF_FFFF, DIV_LAT, 1'b0);
    run("div0", 3'd4, 32'd5, 32'd0, 5'd17,
        32'hFFFF_FFFF, SPC_LAT, 1'b0);
    run("remu0", 3'd7, 32'd5, 32'd0, 5'd18,
        32'd5, SPC_LAT, 1'b0);
    run("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19,
        32'h8000_0000, SPC_LAT, 1'b0);
    run("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20,
        32'd0, SPC_LAT, 1'b0);
    run("repulse", 3'd7, 32'd100, 32'd7, 5'd21,
        32'd2, DIV_LAT, 1'b1);

    // flush in cycle 10 of a divide, restart in cycle 12
    start_i   = 1'b1;
    op_i      = 3'd5;
    rs1_i     = 32'd1000;
    rs2_i     = 32'd3;
    wb_addr_i = 5'd22;
    @(posedge clk); #1;
    start_i = 1'b0;
    seen = 0;
    for (int i = 1; i < 10; i++) begin
      if (done_o) seen++;
      @(posedge clk); #1;
    end
    chk("fl_busy10", 64'(busy_o), 64'd1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("fl_idle11", 64'(busy_o), 64'd0);
    chk("fl_done11", 64'(done_o), 64'd0);
    chk("fl_nodone", 64'(seen), 64'd0);
    chk("fl_res_hold", 64'(result_o), 64'd2);
    @(posedge clk); #1;
    run("after_fl", 3'd5, 32'd100, 32'd7, 5'd23,
        32'd14, DIV_LAT, 1'b0);

    // start and flush together in IDLE: nothing accepted
    start_i   = 1'b1;
    flush_i   = 1'b1;
    op_i      = 3'd0;
    rs1_i     = 32'd2;
    rs2_i     = 32'd2;
    wb_addr_i = 5'd24;
    @(posedge clk); #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    chk("sf_busy", 64'(busy_o), 64'd0);
    chk("sf_wb", 64'(wb_addr_o), 64'd23);

    // reset in the middle of an iterative divide
    start_i   = 1'b1;
    op_i      = 3'd5;
    rs1_i     = 32'd50;
    rs2_i     = 32'd5;
    wb_addr_i = 5'd25;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mr_busy", 64'(busy_o), 64'd1);
    rst = 1'b1;
    #1;
    chk("mr_busy0", 64'(busy_o), 64'd0);
    chk("mr_done0", 64'(done_o), 64'd0);
    chk("mr_res0", 64'(result_o), 64'd0);
    chk("mr_wb0", 64'(wb_addr_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) seen++;
      @(posedge clk); #1;
    end
    chk("mr_nodone", 64'(seen), 64'd0);
    run("after_rst", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd26,
        32'hFFFF_FFEB, MUL_LAT, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
